// File: rtl/pc_pkg.sv
// Shared types and default sizing for the program-counter / fetch sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int unsigned PC_D          = 10;
  localparam int unsigned PC_START_ADDR = 0;
  localparam int unsigned PC_CW         = 16;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: absolute target, signed relative offset, or sequential +1.
module pc_next_calc #(
  parameter int unsigned D = 10
) (
  input  logic [D-1:0] prog_ctr,
  input  logic [D-1:0] target,
  input  logic         abs_jump_en,
  input  logic         rel_jump_en,
  output logic [D-1:0] next_pc
);

  // Two's-complement offset and unsigned mod-2**D add are the same D-bit sum.
  always_comb begin
    next_pc = prog_ctr + D'(1);
    if (abs_jump_en) begin
      next_pc = target;
    end else if (rel_jump_en) begin
      next_pc = prog_ctr + target;
    end
  end

endmodule

// File: rtl/prog_ctr_fsm.sv
// Program counter with start/halt sequencing and a saturating retired-instruction
// counter; prog_ctr addresses instruction memory.
//
//   state | meaning
//   IDLE  | out of reset, fetch gated, waiting for start
//   RUN   | fetching; PC advances on every non-stalled edge
//   HALT  | halt instruction retired, PC frozen, waiting for start
module prog_ctr_fsm
  import pc_pkg::*;
#(
  parameter int unsigned D          = PC_D,
  parameter int unsigned START_ADDR = PC_START_ADDR,
  parameter int unsigned CW         = PC_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          abs_jump_en,
  input  logic          rel_jump_en,
  input  logic          halt_req,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] retired
);

  localparam logic [D-1:0] START_PC = D'(START_ADDR);

  pc_state_t      state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [CW-1:0]  retired_q, retired_d;
  logic           running_q, running_d;
  logic           done_q, done_d;
  logic [D-1:0]   next_pc;

  pc_next_calc #(.D(D)) u_next (
    .prog_ctr    (pc_q),
    .target      (target),
    .abs_jump_en (abs_jump_en),
    .rel_jump_en (rel_jump_en),
    .next_pc     (next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      retired_q <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      RUN: begin
        if (!stall) begin
          if (retired_q != '1) begin
            retired_d = retired_q + CW'(1);
          end
          // Halt retires in place; any jump presented alongside it is dropped.
          if (halt_req) begin
            state_d = HALT;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      IDLE, HALT: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = START_PC;
          retired_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Status flags register the decode of the next state so they track state_q.
    running_d = (state_d == RUN);
    done_d    = (state_d == HALT);
  end

  assign prog_ctr = pc_q;
  assign running  = running_q;
  assign done     = done_q;
  assign retired  = retired_q;

  // abs+rel together is legal; it is tracked here to confirm abs takes precedence.
  assert property (@(posedge clk) disable iff (reset)
    (state_q == RUN && !stall && !halt_req && abs_jump_en && rel_jump_en)
      |=> (pc_q == $past(target)));

  assert property (@(posedge clk) disable iff (reset) !(running_q && done_q));

endmodule

// File: tb/tb_prog_ctr_fsm.sv
// Scoreboard bench for prog_ctr_fsm: directed scenarios, saturation on a narrow
// counter instance, and a random run against a behavioural model.
module tb_prog_ctr_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stall, abs_jump_en, rel_jump_en, halt_req;
  logic [9:0]  target;
  logic [9:0]  prog_ctr;
  logic        running, done;
  logic [15:0] retired;
  logic [9:0]  sat_pc;
  logic        sat_running, sat_done;
  logic [3:0]  sat_retired;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0]  pc;
    logic        run;
    logic        dn;
    logic [15:0] ret;
  } exp_t;

  exp_t exp_q[$];

  // model state for the random phase (0 idle, 1 run, 2 halt)
  int          m_state;
  logic [9:0]  m_pc;
  logic [15:0] m_ret;

  always #5 clk = ~clk;

  prog_ctr_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .abs_jump_en (abs_jump_en),
    .rel_jump_en (rel_jump_en),
    .halt_req    (halt_req),
    .target      (target),
    .prog_ctr    (prog_ctr),
    .running     (running),
    .done        (done),
    .retired     (retired)
  );

  prog_ctr_fsm #(.CW(4)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .abs_jump_en (abs_jump_en),
    .rel_jump_en (rel_jump_en),
    .halt_req    (halt_req),
    .target      (target),
    .prog_ctr    (sat_pc),
    .running     (sat_running),
    .done        (sat_done),
    .retired     (sat_retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".pc"},      32'(prog_ctr), 32'h0);
    chk({tag, ".running"}, 32'(running),  32'h0);
    chk({tag, ".done"},    32'(done),     32'h0);
    chk({tag, ".retired"}, 32'(retired),  32'h0);
  endtask

  task automatic step(input logic st, input logic sl, input logic ab, input logic rl,
                      input logic hl, input logic [9:0] tg, input logic [9:0] e_pc,
                      input logic e_run, input logic e_done, input logic [15:0] e_ret,
                      input string tag);
    exp_t e;
    start = st; stall = sl; abs_jump_en = ab; rel_jump_en = rl; halt_req = hl; target = tg;
    exp_q.push_back('{pc: e_pc, run: e_run, dn: e_done, ret: e_ret});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".pc"},      32'(prog_ctr), 32'(e.pc));
    chk({tag, ".running"}, 32'(running),  32'(e.run));
    chk({tag, ".done"},    32'(done),     32'(e.dn));
    chk({tag, ".retired"}, 32'(retired),  32'(e.ret));
  endtask

  task automatic plain(input logic [9:0] e_pc, input logic [15:0] e_ret, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h155, e_pc, 1'b1, 1'b0, e_ret, tag);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 0; stall = 0; abs_jump_en = 0; rel_jump_en = 0; halt_req = 0; target = '0;
    #12;
    check_reset_state("por");
    release_reset();

    // T2: start then five sequential fetches
    step(1, 0, 0, 0, 0, 10'h0, 10'h000, 1, 0, 16'd0, "t2.start");
    for (int i = 1; i <= 5; i++) plain(10'(i), 16'(i), $sformatf("t2.seq%0d", i));

    // T1: asynchronous reset between edges while running at PC=7
    plain(10'h006, 16'd6, "t1.pre6");
    plain(10'h007, 16'd7, "t1.pre7");
    async_reset();
    check_reset_state("t1.mid");
    release_reset();
    step(1, 0, 0, 0, 0, 10'h0, 10'h000, 1, 0, 16'd0, "t1.restart");
    for (int i = 1; i <= 4; i++) plain(10'(i), 16'(i), $sformatf("t1.seq%0d", i));

    // T3: relative back/forward, then absolute
    step(0, 0, 0, 1, 0, 10'h3FF, 10'h003, 1, 0, 16'd5, "t3.rel_m1");
    step(0, 0, 0, 1, 0, 10'h014, 10'h017, 1, 0, 16'd6, "t3.rel_p20");
    step(0, 0, 1, 0, 0, 10'h200, 10'h200, 1, 0, 16'd7, "t3.abs");

    // T4: wrap at top of address space, abs beats rel
    step(0, 0, 1, 0, 0, 10'h3FF, 10'h3FF, 1, 0, 16'd8, "t4.to_top");
    plain(10'h000, 16'd9, "t4.wrap");
    plain(10'h001, 16'd10, "t4.seq1");
    plain(10'h002, 16'd11, "t4.seq2");
    step(0, 0, 1, 1, 0, 10'h009, 10'h009, 1, 0, 16'd12, "t4.abs_rel");
    step(0, 0, 1, 0, 0, 10'h002, 10'h002, 1, 0, 16'd13, "t4.to2");
    step(0, 0, 0, 1, 0, 10'h3FB, 10'h3FD, 1, 0, 16'd14, "t4.rel_m5");

    // T5: stall holds everything, jump not latched; release applies it
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, 0, 10'h005, 10'h3FD, 1, 0, 16'd14, $sformatf("t5.stall%0d", i));
    step(0, 0, 0, 1, 0, 10'h005, 10'h002, 1, 0, 16'd15, "t5.release");
    step(0, 1, 0, 0, 1, 10'h000, 10'h002, 1, 0, 16'd15, "t5.stalled_halt");

    // T6: halt beats jump, frozen in HALT, start restarts
    step(0, 0, 1, 0, 0, 10'h006, 10'h006, 1, 0, 16'd16, "t6.to6");
    step(0, 0, 1, 0, 1, 10'h009, 10'h006, 0, 1, 16'd17, "t6.halt");
    step(0, 1, 1, 0, 0, 10'h01F, 10'h006, 0, 1, 16'd17, "t6.abs_in_halt");
    step(0, 0, 0, 1, 0, 10'h003, 10'h006, 0, 1, 16'd17, "t6.rel_in_halt");
    step(1, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 16'd0, "t6.start");
    step(1, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 16'd1, "t6.start_in_run");

    // Saturation on the 4-bit counter instance
    async_reset();
    chk("sat.reset", 32'(sat_retired), 32'h0);
    release_reset();
    step(1, 0, 0, 0, 0, 10'h0, 10'h000, 1, 0, 16'd0, "sat.start");
    for (int i = 1; i <= 20; i++) begin
      plain(10'(i), 16'(i), $sformatf("sat.seq%0d", i));
      chk($sformatf("sat.ret%0d", i), 32'(sat_retired), (i > 15) ? 32'd15 : 32'(i));
    end

    // Random run against a behavioural model
    async_reset();
    check_reset_state("rnd.reset");
    release_reset();
    m_state = 0; m_pc = '0; m_ret = '0;
    for (int n = 0; n < 300; n++) begin
      logic st, sl, ab, rl, hl;
      logic [9:0] tg;
      st = ($urandom_range(0, 7) == 0);
      sl = ($urandom_range(0, 4) == 0);
      ab = ($urandom_range(0, 5) == 0);
      rl = ($urandom_range(0, 4) == 0);
      hl = ($urandom_range(0, 19) == 0);
      tg = 10'($urandom_range(0, 1023));
      if (m_state == 1) begin
        if (!sl) begin
          if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
          if (hl)      m_state = 2;
          else if (ab) m_pc = tg;
          else if (rl) m_pc = m_pc + tg;
          else         m_pc = m_pc + 10'd1;
        end
      end else if (st) begin
        m_state = 1; m_pc = '0; m_ret = '0;
      end
      step(st, sl, ab, rl, hl, tg, m_pc, m_state == 1, m_state == 2, m_ret,
           $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
